// File: rtl/spi_txn_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_txn_sched_if
// Brief    : Requester, response and byte-shifter signals of spi_txn_sched.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_txn_sched_if;
  logic       req0_valid;
  logic       req0_ready;
  logic       req0_wr;
  logic [2:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req1_valid;
  logic       req1_ready;
  logic       req1_wr;
  logic [2:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       cs_n;
  logic       bx_start;
  logic [7:0] bx_tx;
  logic       bx_done;
  logic [7:0] bx_rx;
  logic       busy;

  // Scheduler side.
  modport master (
    input  req0_valid, req0_wr, req0_addr, req0_wdata,
    input  req1_valid, req1_wr, req1_addr, req1_wdata,
    input  bx_done, bx_rx,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_rdata, rsp_err,
    output cs_n, bx_start, bx_tx, busy
  );

  // Requesters, byte shifter and observers.
  modport slave (
    output req0_valid, req0_wr, req0_addr, req0_wdata,
    output req1_valid, req1_wr, req1_addr, req1_wdata,
    output bx_done, bx_rx,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
    input  cs_n, bx_start, bx_tx, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_txn_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_txn_sched
// Brief    : Two-requester SPI register-transaction scheduler driving an
//            external byte shifter. Optional byte-phase watchdog enabled by
//            the macro SPI_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_txn_sched #(
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2,
  parameter int GAP_CYC      = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  wire logic        clk,
  input  wire logic        rst,
  spi_txn_sched_if.master  bus
);

  // One shared counter, sized for the longest interval it ever has to time.
  localparam int c_MAX_A   = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int c_MAX_B   = (c_MAX_A > GAP_CYC) ? c_MAX_A : GAP_CYC;
  localparam int c_MAX_C   = (c_MAX_B > TIMEOUT_CYC) ? c_MAX_B : TIMEOUT_CYC;
  localparam int c_CNT_W   = ($clog2(c_MAX_C + 1) < 8) ? 8 : $clog2(c_MAX_C + 1);

  localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_BYTE1 = 3'd2,
    S_BYTE2 = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic                 r_first;
  logic                 w_first_nxt;

  logic                 r_wr;
  logic [2:0]           r_addr;
  logic [7:0]           r_wdata;
  logic                 r_id;
  logic                 r_last_grant;
  logic [7:0]           r_rdata;

  logic                 r_rsp_valid;
  logic                 r_rsp_id;
  logic [7:0]           r_rsp_rdata;

  logic                 w_grant_vld;
  logic                 w_grant_id;
  logic                 w_latch;
  logic                 w_capture;
  logic                 w_rsp_fire;

  // Ties go to the requester that was not served last.
  assign w_grant_vld = bus.req0_valid | bus.req1_valid;
  assign w_grant_id  = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
  logic r_rsp_err;
  logic w_rsp_err;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = 1'b0;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_rsp_fire  = 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
    w_rsp_err   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == c_SETUP_LAST) begin
          w_cnt_nxt   = '0;
          w_first_nxt = 1'b1;
          w_state_nxt = S_BYTE1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      S_BYTE1, S_BYTE2: begin
        if (bus.bx_done) begin
          w_cnt_nxt = '0;
          if (r_state == S_BYTE1) begin
            w_first_nxt = 1'b1;
            w_state_nxt = S_BYTE2;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
`ifdef SPI_SCHED_TIMEOUT_EN
        // Counter is zero on the bx_start cycle, so it restarts per byte.
        else if (r_cnt == c_TO_LAST) begin
          w_cnt_nxt   = '0;
          w_rsp_fire  = 1'b1;
          w_rsp_err   = 1'b1;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
`endif
      end
      S_HOLD: begin
        if (r_cnt == c_HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_rsp_fire  = 1'b1;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      S_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_first      <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= 3'd0;
      r_wdata      <= 8'h00;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_rdata      <= 8'h00;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_rdata  <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_first     <= w_first_nxt;
      r_rsp_valid <= w_rsp_fire;
      if (w_latch) begin
        r_wr         <= w_grant_id ? bus.req1_wr    : bus.req0_wr;
        r_addr       <= w_grant_id ? bus.req1_addr  : bus.req0_addr;
        r_wdata      <= w_grant_id ? bus.req1_wdata : bus.req0_wdata;
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (w_capture) begin
        r_rdata <= r_wr ? 8'h00 : bus.bx_rx;
      end
      if (w_rsp_fire) begin
        r_rsp_id <= r_id;
`ifdef SPI_SCHED_TIMEOUT_EN
        r_rsp_rdata <= w_rsp_err ? 8'h00 : r_rdata;
`else
        r_rsp_rdata <= r_rdata;
`endif
      end
    end
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_err <= 1'b0;
    end else if (w_rsp_fire) begin
      r_rsp_err <= w_rsp_err;
    end
  end
  assign bus.rsp_err = r_rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // Outputs decode straight from state so the async reset releases cs_n at once.
  always_comb begin
    bus.bx_tx = 8'h00;
    case (r_state)
      S_BYTE1: bus.bx_tx = {~r_wr, 4'b0000, r_addr};
      S_BYTE2: bus.bx_tx = r_wr ? r_wdata : 8'h00;
      default: bus.bx_tx = 8'h00;
    endcase
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.cs_n       = ~((r_state == S_SETUP) || (r_state == S_BYTE1) ||
                            (r_state == S_BYTE2) || (r_state == S_HOLD));
  assign bus.bx_start   = r_first && ((r_state == S_BYTE1) || (r_state == S_BYTE2));
  assign bus.req0_ready = (r_state == S_IDLE) && w_grant_vld && !w_grant_id;
  assign bus.req1_ready = (r_state == S_IDLE) && w_grant_vld &&  w_grant_id;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_rdata  = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_txn_sched
// Brief    : Directed self-checking bench for spi_txn_sched with a byte
//            shifter model of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_txn_sched;

  localparam int c_TO = 16;

  logic clk = 1'b0;
  logic rst;
  spi_txn_sched_if bus();

  spi_txn_sched #(
    .CS_SETUP_CYC (2),
    .CS_HOLD_CYC  (2),
    .GAP_CYC      (4),
    .TIMEOUT_CYC  (c_TO)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Shifter model controls and state.
  int         sh_lat  = 0;
  logic [7:0] sh_rx   = 8'h00;
  bit         sh_hang = 1'b0;
  bit         sh_pend = 1'b0;
  int         sh_cd   = 0;

  // Monitor results.
  int         cyc = 0;
  logic [7:0] tx_log[$];
  int         grants[$];
  int         grant_cyc[$];
  int         rsp_cnt = 0;
  logic       rsp_id_q = 1'b0;
  logic [7:0] rsp_rdata_q = 8'h00;
  logic       rsp_err_q = 1'b0;
  int         ready1_cnt = 0;
  int         viol_ready = 0;
  int         viol_cs = 0;
  int         cs_low = 0;
  int         hi_run = 0;
  int         last_hi = 0;
  int         last_start_cyc = 0;
  int         last_rsp_cyc = 0;

  always @(negedge clk) begin
    bus.bx_done = 1'b0;
    if (!rst) begin
      sh_pend = 1'b0;
    end else begin
      if (sh_pend) begin
        if (sh_cd == 0) begin
          bus.bx_done = 1'b1;
          bus.bx_rx   = sh_rx;
          sh_pend     = 1'b0;
        end else begin
          sh_cd = sh_cd - 1;
        end
      end
      if (bus.bx_start && !sh_hang) begin
        if (sh_lat == 0) begin
          bus.bx_done = 1'b1;
          bus.bx_rx   = sh_rx;
        end else begin
          sh_pend = 1'b1;
          sh_cd   = sh_lat - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.bx_start) begin
      tx_log.push_back(bus.bx_tx);
      last_start_cyc = cyc;
    end
    if (bus.rsp_valid) begin
      rsp_cnt      = rsp_cnt + 1;
      rsp_id_q     = bus.rsp_id;
      rsp_rdata_q  = bus.rsp_rdata;
      rsp_err_q    = bus.rsp_err;
      last_rsp_cyc = cyc;
    end
    if (bus.req0_ready) begin
      grants.push_back(0);
      grant_cyc.push_back(cyc);
    end
    if (bus.req1_ready) begin
      grants.push_back(1);
      grant_cyc.push_back(cyc);
      ready1_cnt = ready1_cnt + 1;
    end
    if ((bus.req0_ready || bus.req1_ready) && bus.busy) viol_ready = viol_ready + 1;
    if (bus.req0_ready && bus.req1_ready) viol_ready = viol_ready + 1;
    if (!bus.cs_n && (!bus.busy || bus.rsp_valid)) viol_cs = viol_cs + 1;
    if (!bus.cs_n) begin
      cs_low = cs_low + 1;
      if (hi_run > 0) last_hi = hi_run;
      hi_run = 0;
    end else begin
      hi_run = hi_run + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input bit wr, input logic [2:0] addr, input logic [7:0] wdata);
    int b_g;
    bit got;
    b_g = grants.size();
    got = 1'b0;
    if (id) begin
      bus.req1_wr = wr; bus.req1_addr = addr; bus.req1_wdata = wdata; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_wr = wr; bus.req0_addr = addr; bus.req0_wdata = wdata; bus.req0_valid = 1'b1;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (grants.size() > b_g) got = 1'b1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("grant_wait", 32'(got), 32'd1);
  endtask

  task automatic wait_rsp(input int target);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (rsp_cnt >= target) got = 1'b1;
    end
    check("rsp_wait", 32'(got), 32'd1);
  endtask

  initial begin
    int b_tx, b_rsp, b_cs, b_g, b_r1;
    bit got;
    rst = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_wr = 1'b0; bus.req0_addr = 3'd0; bus.req0_wdata = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_wr = 1'b0; bus.req1_addr = 3'd0; bus.req1_wdata = 8'h00;
    bus.bx_done = 1'b0; bus.bx_rx = 8'h00;
    repeat (3) tick();

    check("rst_cs_n",      32'(bus.cs_n),       32'd1);
    check("rst_bx_start",  32'(bus.bx_start),   32'd0);
    check("rst_bx_tx",     32'(bus.bx_tx),      32'h00);
    check("rst_busy",      32'(bus.busy),       32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid),  32'd0);
    check("rst_rsp_id",    32'(bus.rsp_id),     32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata),  32'h00);
    check("rst_rsp_err",   32'(bus.rsp_err),    32'd0);
    check("rst_ready",     32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    rst = 1'b1;
    tick();

    // Read chip ID from requester 0, 2-cycle shifter.
    sh_lat = 2; sh_rx = 8'h07;
    b_tx = tx_log.size(); b_rsp = rsp_cnt; b_cs = cs_low;
    issue(1'b0, 1'b0, 3'd0, 8'h00);
    wait_rsp(b_rsp + 1);
    repeat (2) tick();
    check("rd_tx1",   32'(tx_log[b_tx]),     32'h80);
    check("rd_tx2",   32'(tx_log[b_tx + 1]), 32'h00);
    check("rd_pulse", 32'(rsp_cnt - b_rsp),  32'd1);
    check("rd_id",    32'(rsp_id_q),         32'd0);
    check("rd_rdata", 32'(rsp_rdata_q),      32'h07);
    check("rd_err",   32'(rsp_err_q),        32'd0);
    check("rd_cs_low", 32'(cs_low - b_cs),   32'd10);
    repeat (6) tick();

    // Write LEDs from requester 1; shifter returns junk that must be dropped.
    sh_lat = 1; sh_rx = 8'h5A;
    b_tx = tx_log.size(); b_rsp = rsp_cnt; b_cs = cs_low; b_r1 = ready1_cnt;
    issue(1'b1, 1'b1, 3'd3, 8'hA5);
    wait_rsp(b_rsp + 1);
    repeat (2) tick();
    check("wr_tx1",    32'(tx_log[b_tx]),     32'h03);
    check("wr_tx2",    32'(tx_log[b_tx + 1]), 32'hA5);
    check("wr_id",     32'(rsp_id_q),         32'd1);
    check("wr_rdata",  32'(rsp_rdata_q),      32'h00);
    check("wr_ready1", 32'(ready1_cnt - b_r1), 32'd1);
    check("wr_cs_low", 32'(cs_low - b_cs),    32'd8);
    repeat (6) tick();

    // Fairness and back-to-back timing with a zero-latency shifter.
    sh_lat = 0; sh_rx = 8'h11;
    b_g = grants.size(); b_rsp = rsp_cnt;
    bus.req0_wr = 1'b0; bus.req0_addr = 3'd1; bus.req0_wdata = 8'h00; bus.req0_valid = 1'b1;
    bus.req1_wr = 1'b1; bus.req1_addr = 3'd2; bus.req1_wdata = 8'h3C; bus.req1_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (grants.size() >= b_g + 4) got = 1'b1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("fair_grants_wait", 32'(got), 32'd1);
    wait_rsp(b_rsp + 4);
    repeat (2) tick();
    check("fair_g0", 32'(grants[b_g]),     32'd0);
    check("fair_g1", 32'(grants[b_g + 1]), 32'd1);
    check("fair_g2", 32'(grants[b_g + 2]), 32'd0);
    check("fair_g3", 32'(grants[b_g + 3]), 32'd1);
    check("fair_period", 32'(grant_cyc[b_g + 1] - grant_cyc[b_g]), 32'd11);
    check("fair_gap_hi", 32'(last_hi),      32'd5);
    check("fair_rsps",   32'(rsp_cnt - b_rsp), 32'd4);
    check("fair_last_id", 32'(rsp_id_q),    32'd1);
    check("fair_ready_busy", 32'(viol_ready), 32'd0);
    check("cs_outside_txn",  32'(viol_cs),    32'd0);
    repeat (6) tick();

    // Slow shifter: 8 cycles per byte.
    sh_lat = 8; sh_rx = 8'hC3;
    b_tx = tx_log.size(); b_rsp = rsp_cnt; b_cs = cs_low;
    issue(1'b0, 1'b0, 3'd6, 8'h00);
    wait_rsp(b_rsp + 1);
    repeat (2) tick();
    check("slow_tx1",    32'(tx_log[b_tx]), 32'h86);
    check("slow_cs_low", 32'(cs_low - b_cs), 32'd22);
    check("slow_rdata",  32'(rsp_rdata_q),   32'hC3);
    repeat (6) tick();

    // Reset in the middle of BYTE2.
    b_tx = tx_log.size();
    issue(1'b0, 1'b0, 3'd5, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (tx_log.size() >= b_tx + 2) got = 1'b1;
      else tick();
    end
    check("mid_reach_byte2", 32'(got), 32'd1);
    b_rsp = rsp_cnt;
    rst = 1'b0;
    #1;
    check("mid_cs_n",     32'(bus.cs_n),     32'd1);
    check("mid_bx_start", 32'(bus.bx_start), 32'd0);
    check("mid_busy",     32'(bus.busy),     32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) tick();
    check("mid_no_rsp", 32'(rsp_cnt - b_rsp), 32'd0);
    sh_lat = 1; sh_rx = 8'h42;
    b_g = grants.size();
    bus.req0_wr = 1'b0; bus.req0_addr = 3'd1; bus.req0_valid = 1'b1;
    bus.req1_wr = 1'b0; bus.req1_addr = 3'd2; bus.req1_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (grants.size() > b_g) got = 1'b1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("post_rst_grant_wait", 32'(got), 32'd1);
    check("post_rst_tie", 32'(grants[b_g]), 32'd0);
    wait_rsp(b_rsp + 1);
    check("post_rst_id",    32'(rsp_id_q),    32'd0);
    check("post_rst_rdata", 32'(rsp_rdata_q), 32'h42);
    repeat (6) tick();

`ifdef SPI_SCHED_TIMEOUT_EN
    // Shifter that never answers.
    sh_hang = 1'b1;
    b_rsp = rsp_cnt;
    issue(1'b1, 1'b0, 3'd4, 8'h00);
    wait_rsp(b_rsp + 1);
    check("to_delay", 32'(last_rsp_cyc - last_start_cyc), 32'(c_TO));
    check("to_err",   32'(rsp_err_q),   32'd1);
    check("to_rdata", 32'(rsp_rdata_q), 32'h00);
    check("to_id",    32'(rsp_id_q),    32'd1);
    sh_hang = 1'b0;
    repeat (6) tick();
    check("to_cs_outside", 32'(viol_cs), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
